dram_port_arbiter: RTL and testbench

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_arb_pkg.sv | 33 +++
 rtl/dram_port_arbiter_if.sv | 46 ++++
 rtl/rr_arb2.sv | 18 +
 rtl/dram_port_arbiter.sv | 114 +++++++++++
 tb/tb_dram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM port arbiter: FSM encoding, line geometry, latched request.
// No logic of its own; pure declarations and one helper.
// Imported by the interface, the round-robin picker and the arbiter top.
package dram_arb_pkg;

    localparam int LINE_ADR_W = 28;   // 16-byte line address, byte address bits [31:4]
    localparam int LINE_W     = 128;
    localparam int MASK_W     = 16;   // 1 = byte not written

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_MON = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [LINE_ADR_W-1:0] adr;
        logic [LINE_W-1:0]     wdata;
        logic [MASK_W-1:0]     mask;
    } line_req_t;

    // One-hot {cpu, monitor} vector for a port owner.
    function automatic logic [1:0] owner_onehot(owner_t o);
        return (o == OWN_CPU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bundle of the two requester ports, the shared memory port and arbiter status.
// No latency; wiring only.
// slave = arbiter side, master = requesters plus memory model side.
interface dram_port_arbiter_if;
    import dram_arb_pkg::*;

    logic                  m_req,   c_req;
    logic                  m_we,    c_we;
    logic [LINE_ADR_W-1:0] m_adr,   c_adr;
    logic [LINE_W-1:0]     m_wdata, c_wdata;
    logic [MASK_W-1:0]     m_mask,  c_mask;
    logic                  m_gnt,   c_gnt;
    logic                  m_done,  c_done;
    logic [LINE_W-1:0]     m_rdata, c_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [LINE_ADR_W-1:0] mem_adr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [MASK_W-1:0]     mem_mask;
    logic                  mem_ack;
    logic [LINE_W-1:0]     mem_rdata;

    logic                  mon_prio;
    logic                  tout_err;
    logic                  busy;

    modport slave (
        input  m_req, m_we, m_adr, m_wdata, m_mask,
        input  c_req, c_we, c_adr, c_wdata, c_mask,
        output m_gnt, m_done, m_rdata, c_gnt, c_done, c_rdata,
        output mem_req, mem_we, mem_adr, mem_wdata, mem_mask,
        input  mem_ack, mem_rdata, mon_prio,
        output tout_err, busy
    );

    modport master (
        output m_req, m_we, m_adr, m_wdata, m_mask,
        output c_req, c_we, c_adr, c_wdata, c_mask,
        input  m_gnt, m_done, m_rdata, c_gnt, c_done, c_rdata,
        input  mem_req, mem_we, mem_adr, mem_wdata, mem_mask,
        output mem_ack, mem_rdata, mon_prio,
        input  tout_err, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: bit0 = monitor, bit1 = cpu, one-hot grant out.
// Combinational, zero latency.
// No backpressure; a lone requester always wins, on a tie the previous loser wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] last_gnt,
    output logic [1:0] gnt
);

    // Tie goes to whoever did not receive the last grant.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates monitor and CPU line requests onto one shared data RAM port.
// Grant in IDLE, mem_req one cycle later, done on ack (or timeout) in WAIT.
// One transaction outstanding; requesters hold req until their grant pulse.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int TOUT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    dram_port_arbiter_if.slave bus
);

    arb_state_t        state_q,    state_d;
    owner_t            owner_q,    owner_d;
    line_req_t         req_q,      req_d;
    logic [TOUT_W-1:0] tout_q,     tout_d;
    logic [1:0]        last_gnt_q, last_gnt_d;

    line_req_t  m_line, c_line;
    logic [1:0] rr_gnt, pick, gnt, done;
    logic       mem_req, ack_ok, tout_fire;

    assign m_line = '{we: bus.m_we, adr: bus.m_adr, wdata: bus.m_wdata, mask: bus.m_mask};
    assign c_line = '{we: bus.c_we, adr: bus.c_adr, wdata: bus.c_wdata, mask: bus.c_mask};

    rr_arb2 u_rr_arb2 (
        .req      ({bus.c_req, bus.m_req}),
        .last_gnt (last_gnt_q),
        .gnt      (rr_gnt)
    );

    // Next-state, request latching, timeout counting and per-cycle pulses.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        tout_d     = tout_q;
        last_gnt_d = last_gnt_q;
        pick       = 2'b00;
        gnt        = 2'b00;
        done       = 2'b00;
        mem_req    = 1'b0;
        ack_ok     = 1'b0;
        tout_fire  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Monitor priority overrides the round-robin pointer but still updates it.
                pick = (bus.mon_prio && bus.m_req) ? 2'b01 : rr_gnt;
                if (pick != 2'b00) begin
                    gnt        = pick;
                    last_gnt_d = pick;
                    owner_d    = pick[1] ? OWN_CPU : OWN_MON;
                    req_d      = pick[1] ? c_line : m_line;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                tout_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack arriving on the all-ones cycle still counts as a normal completion.
                if (bus.mem_ack) begin
                    ack_ok  = 1'b1;
                    done    = owner_onehot(owner_q);
                    state_d = ST_IDLE;
                end else if (tout_q == '1) begin
                    tout_fire = 1'b1;
                    done      = owner_onehot(owner_q);
                    state_d   = ST_IDLE;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched request; reset leaves the pointer favouring the monitor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_MON;
            req_q      <= '0;
            tout_q     <= '0;
            last_gnt_q <= 2'b10;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            tout_q     <= tout_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Grants are combinational from IDLE, so they are held off while reset is asserted.
    assign bus.m_gnt     = gnt[0] & ~rst;
    assign bus.c_gnt     = gnt[1] & ~rst;
    assign bus.m_done    = done[0];
    assign bus.c_done    = done[1];
    assign bus.m_rdata   = (ack_ok && owner_q == OWN_MON) ? bus.mem_rdata : '0;
    assign bus.c_rdata   = (ack_ok && owner_q == OWN_CPU) ? bus.mem_rdata : '0;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = req_q.we;
    assign bus.mem_adr   = req_q.adr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_mask  = req_q.mask;
    assign bus.tout_err  = tout_fire;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomised and directed bench for dram_port_arbiter with a transaction-level model.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Requesters hold req until granted; memory acks after a chosen wait or never.
module tb_dram_port_arbiter;
    import dram_arb_pkg::*;

    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_port_arbiter_if bus_if ();

    dram_port_arbiter #(.TOUT_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // stimulus knobs
    int   p_new [2];
    int   p_drop, p_stray, prio_mode, lat_fixed;
    logic use_fix_data;
    logic [127:0] fix_data;
    logic prio;

    // requester side
    logic         pend  [2];
    logic         r_we  [2];
    logic [27:0]  r_adr [2];
    logic [127:0] r_wd  [2];
    logic [15:0]  r_mk  [2];

    // transaction-level model: 0 free, 1 granted (issue next), 2 waiting for memory
    int           phase, w, lat, last_win, own;
    logic         cur_we;
    logic [27:0]  cur_adr;
    logic [127:0] cur_wd;
    logic [15:0]  cur_mk;

    // observations
    int           obs_g [$];
    int           n_done, n_tout, n_cyc, gnt_cyc, done_cyc;
    logic [127:0] last_rd;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_obs();
        obs_g.delete();
        n_done = 0; n_tout = 0; n_cyc = 0; gnt_cyc = -1; done_cyc = -1;
        last_rd = '0;
    endtask

    task automatic drive_idle();
        bus_if.m_req = 1'b0; bus_if.m_we = 1'b0; bus_if.m_adr = '0; bus_if.m_wdata = '0; bus_if.m_mask = '0;
        bus_if.c_req = 1'b0; bus_if.c_we = 1'b0; bus_if.c_adr = '0; bus_if.c_wdata = '0; bus_if.c_mask = '0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0; bus_if.mon_prio = 1'b0;
    endtask

    task automatic set_req(input int s, input logic we, input logic [27:0] adr,
                           input logic [127:0] wd, input logic [15:0] mk);
        pend[s] = 1'b1; r_we[s] = we; r_adr[s] = adr; r_wd[s] = wd; r_mk[s] = mk;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        bus_if.m_req = 1'b1; bus_if.c_req = 1'b1;   // grants must stay low under reset
        pend[0] = 1'b0; pend[1] = 1'b0;
        @(negedge clk);
        chk("rst_busy",    128'(bus_if.busy), 128'(0));
        chk("rst_mem_req", 128'(bus_if.mem_req), 128'(0));
        chk("rst_gnt",     128'({bus_if.c_gnt, bus_if.m_gnt}), 128'(0));
        chk("rst_done",    128'({bus_if.c_done, bus_if.m_done}), 128'(0));
        chk("rst_tout",    128'(bus_if.tout_err), 128'(0));
        chk("rst_mem_adr", 128'(bus_if.mem_adr), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.m_req = 1'b0; bus_if.c_req = 1'b0;
        phase = 0; w = 0; last_win = 1;
    endtask

    task automatic cycle();
        logic         ack, fin, etout;
        logic [127:0] ad;
        logic [1:0]   eg, ed;
        int           win;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            if (pend[s]) begin
                if ($urandom_range(0, 99) < p_drop) pend[s] = 1'b0;
            end else if ($urandom_range(0, 99) < p_new[s]) begin
                set_req(s, 1'($urandom), 28'($urandom), {$urandom, $urandom, $urandom, $urandom},
                        16'($urandom));
            end
        end
        case (prio_mode)
            1:       prio = 1'b0;
            2:       prio = 1'b1;
            default: if ($urandom_range(0, 9) == 0) prio = ~prio;
        endcase
        ack = (phase == 2) ? (w == lat) : ($urandom_range(0, 99) < p_stray);
        ad  = use_fix_data ? fix_data : {$urandom, $urandom, $urandom, $urandom};
        bus_if.m_req = pend[0]; bus_if.m_we = r_we[0]; bus_if.m_adr = r_adr[0];
        bus_if.m_wdata = r_wd[0]; bus_if.m_mask = r_mk[0];
        bus_if.c_req = pend[1]; bus_if.c_we = r_we[1]; bus_if.c_adr = r_adr[1];
        bus_if.c_wdata = r_wd[1]; bus_if.c_mask = r_mk[1];
        bus_if.mon_prio = prio; bus_if.mem_ack = ack; bus_if.mem_rdata = ad;

        @(negedge clk);
        eg = 2'b00; win = -1;
        if (phase == 0 && (pend[0] || pend[1])) begin
            if (prio && pend[0])          win = 0;
            else if (pend[0] && pend[1])  win = 1 - last_win;
            else                          win = pend[0] ? 0 : 1;
            eg[win] = 1'b1;
        end
        chk("gnt", 128'({bus_if.c_gnt, bus_if.m_gnt}), 128'(eg));
        chk("mem_req", 128'(bus_if.mem_req), 128'(phase == 1));
        if (phase == 1) begin
            chk("mem_we",    128'(bus_if.mem_we), 128'(cur_we));
            chk("mem_adr",   128'(bus_if.mem_adr), 128'(cur_adr));
            chk("mem_wdata", bus_if.mem_wdata, cur_wd);
            chk("mem_mask",  128'(bus_if.mem_mask), 128'(cur_mk));
        end
        chk("busy", 128'(bus_if.busy), 128'(phase != 0));
        fin   = (phase == 2) && (ack || w == TMAX);
        etout = (phase == 2) && !ack && (w == TMAX);
        ed = 2'b00;
        if (fin) ed[own] = 1'b1;
        chk("done", 128'({bus_if.c_done, bus_if.m_done}), 128'(ed));
        chk("tout_err", 128'(bus_if.tout_err), 128'(etout));
        if (fin) begin
            chk("owner_rdata", (own == 0) ? bus_if.m_rdata : bus_if.c_rdata, ack ? ad : 128'(0));
            chk("other_rdata", (own == 0) ? bus_if.c_rdata : bus_if.m_rdata, 128'(0));
        end

        if (bus_if.m_gnt) obs_g.push_back(0);
        if (bus_if.c_gnt) obs_g.push_back(1);
        if ((bus_if.m_gnt || bus_if.c_gnt) && gnt_cyc < 0) gnt_cyc = n_cyc;
        if (bus_if.m_done || bus_if.c_done) begin
            n_done++;
            done_cyc = n_cyc;
            last_rd  = bus_if.m_done ? bus_if.m_rdata : bus_if.c_rdata;
        end
        if (bus_if.tout_err) n_tout++;
        n_cyc++;

        if (win >= 0) begin
            pend[win] = 1'b0;
            cur_we = r_we[win]; cur_adr = r_adr[win]; cur_wd = r_wd[win]; cur_mk = r_mk[win];
            own = win; last_win = win; phase = 1;
        end else if (phase == 1) begin
            phase = 2; w = 0;
            lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, TMAX + 2));
        end else if (phase == 2) begin
            if (fin) phase = 0;
            else     w++;
        end
    endtask

    task automatic directed_knobs(input int pm, input int lf);
        p_new[0] = 0; p_new[1] = 0; p_drop = 0; p_stray = 0;
        prio_mode = pm; lat_fixed = lf; use_fix_data = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_alt [4];
        rst = 1'b1;
        drive_idle();
        prio = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
        phase = 0; w = 0; lat = 0; last_win = 1; own = 0;
        cur_we = 1'b0; cur_adr = '0; cur_wd = '0; cur_mk = '0;
        directed_knobs(1, 1);
        clr_obs();
        do_reset();

        // single monitor read: gnt cycle 0, mem_req cycle 1, ack and done cycle 3
        directed_knobs(1, 1);
        use_fix_data = 1'b1; fix_data = {16{8'hA5}};
        set_req(0, 1'b0, 28'h0000010, 128'(0), 16'h0000);
        clr_obs();
        repeat (6) cycle();
        chk("t1_gnt_cycle", 128'(gnt_cyc), 128'(0));
        chk("t1_done_cycle", 128'(done_cyc), 128'(3));
        chk("t1_done_cnt", 128'(n_done), 128'(1));
        chk("t1_rdata", last_rd, {16{8'hA5}});

        // both continuous, no priority: M,C,M,C
        do_reset();
        directed_knobs(1, 0);
        p_new[0] = 100; p_new[1] = 100;
        clr_obs();
        repeat (16) cycle();
        exp_alt = '{0, 1, 0, 1};
        chk("t2_ngrants_ge4", 128'(obs_g.size() >= 4), 128'(1));
        for (int i = 0; i < 4 && i < obs_g.size(); i++) chk("t2_alt", 128'(obs_g[i]), 128'(exp_alt[i]));

        // both continuous, monitor priority: monitor only
        do_reset();
        directed_knobs(2, 0);
        p_new[0] = 100; p_new[1] = 100;
        clr_obs();
        repeat (16) cycle();
        chk("t3_ngrants_ge4", 128'(obs_g.size() >= 4), 128'(1));
        for (int i = 0; i < 4 && i < obs_g.size(); i++) chk("t3_mon", 128'(obs_g[i]), 128'(0));
        chk("t3_cpu_grants", 128'(obs_g.sum() with (int'(item == 1))), 128'(0));

        // cpu write never acked: timeout after 2^TW wait cycles
        do_reset();
        directed_knobs(1, 1000);
        set_req(1, 1'b1, 28'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'h0fff);
        clr_obs();
        repeat (20) cycle();
        chk("t4_tout_cnt", 128'(n_tout), 128'(1));
        chk("t4_done_cnt", 128'(n_done), 128'(1));
        chk("t4_done_cycle", 128'(done_cyc), 128'(TMAX + 2));
        chk("t4_busy", 128'(bus_if.busy), 128'(0));
        set_req(0, 1'b0, 28'($urandom), 128'(0), 16'h0000);
        clr_obs();
        repeat (3) cycle();
        chk("t4_next_gnt", 128'(obs_g.size()), 128'(1));

        // reset while waiting, stray acks afterwards are ignored
        do_reset();
        directed_knobs(1, 1000);
        set_req(0, 1'b0, 28'($urandom), 128'(0), 16'h0000);
        repeat (6) cycle();
        chk("t5_busy_before", 128'(bus_if.busy), 128'(1));
        do_reset();
        p_stray = 100;
        clr_obs();
        repeat (3) cycle();
        p_stray = 0;
        chk("t5_done_cnt", 128'(n_done), 128'(0));
        chk("t5_busy", 128'(bus_if.busy), 128'(0));

        // ack on the exact timeout cycle completes normally
        do_reset();
        directed_knobs(1, TMAX);
        set_req(1, 1'b0, 28'($urandom), 128'(0), 16'h0000);
        clr_obs();
        repeat (20) cycle();
        chk("t6_tout_cnt", 128'(n_tout), 128'(0));
        chk("t6_done_cnt", 128'(n_done), 128'(1));

        // randomised traffic against the model
        do_reset();
        p_new[0] = 35; p_new[1] = 35; p_drop = 5; p_stray = 15;
        prio_mode = 0; lat_fixed = -1; use_fix_data = 1'b0;
        clr_obs();
        repeat (3000) cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
